fg_input_controller: RTL and testbench
======================================

// Module: fg_input_controller
// PURPOSE
//   Front-panel controller for the function generator. Three asynchronous push-buttons
//   (mode/up/down) are synchronised, debounced and edge-detected inside the block.
//   The resulting press events sequence waveform-select and frequency-step updates.
//   Each new configuration goes to the waveform core over a valid/ready handshake.
// PARAMETERS
//   SYNC_STAGES     2    flops per synchroniser chain (>=2)
//   DEBOUNCE_CYCLES 1000 consecutive clk_i cycles an input must differ before accepted (>=2)
//   WAVE_NUM        4    number of waveforms; wave_sel_o counts 0..WAVE_NUM-1 (2..4)
//   FREQ_W          8    width of frequency step word
//   FREQ_MIN        1    lowest frequency step (saturation floor, reset value)
//   FREQ_MAX        255  highest frequency step (saturation ceiling, <= 2**FREQ_W-1)
// PORTS
//   clk_i        in   1       system clock
//   rstn_i       in   1       reset, asynchronous, active-low
//   btn_mode_i   in   1       async button, cycles waveform
//   btn_up_i     in   1       async button, frequency step +1
//   btn_down_i   in   1       async button, frequency step -1
//   wave_sel_o   out  2       current waveform index
//   freq_step_o  out  FREQ_W  current frequency step
//   cfg_valid_o  out  1       config on wave_sel_o/freq_step_o offered to core
//   cfg_ready_i  in   1       core accepts config (handshake completes when valid&ready)
//   busy_o       out  1       high while not in IDLE
// BEHAVIOUR
//   Reset: all sync flops 0, debounced levels 0, debounce counters 0, wave_sel_o=0,
//     freq_step_o=FREQ_MIN, cfg_valid_o=0, busy_o=1, state=INIT.
//   Sync: per button, SYNC_STAGES-flop chain; every stage async-reset to 0.
//   Debounce: per button, counter clears whenever sync==stable; increments while they
//     differ; on the DEBOUNCE_CYCLES-th consecutive mismatch cycle stable takes sync, counter clears.
//   Event: combinational pulse = stable rising edge (0->1), exactly 1 cycle per press;
//     release (1->0) produces no event.
//   FSM states INIT, IDLE, SEND:
//     INIT -> SEND on first edge after reset release (publishes default config).
//     IDLE: on event update registers at the same edge and go to SEND.
//       Priority when simultaneous: mode > up > down; lower-priority events dropped.
//       mode: wave_sel_o+1, WAVE_NUM-1 wraps to 0.
//       up: freq_step_o+1, saturates at FREQ_MAX. down: -1, saturates at FREQ_MIN.
//       Press that leaves freq_step_o unchanged (already saturated): stay IDLE, no handshake.
//     SEND: cfg_valid_o=1; outputs held stable; on cfg_ready_i=1 -> IDLE, cfg_valid_o=0 next cycle.
//       Events arriving in SEND are dropped (no queueing).
//   cfg_valid_o registered; high exactly in SEND. busy_o=1 in INIT and SEND.
//   Latency: input level stable from edge k -> stable updates at edge
//     k+SYNC_STAGES+DEBOUNCE_CYCLES-1; cfg_valid_o high after the following edge.
//   Glitch shorter than DEBOUNCE_CYCLES synchronised cycles: no event.
//   Reset mid-handshake: cfg_valid_o drops immediately (async); values return to reset values.
// TESTING (bench: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, WAVE_NUM=4, FREQ_MIN=1, FREQ_MAX=3)
//   Release reset, cfg_ready_i=1 -> cfg_valid_o 1 cycle with wave=0,freq=1, then busy_o=0.
//   btn_mode_i high held 10 cycles, x4 presses -> wave_sel_o 1,2,3,0; one handshake per press.
//   btn_up_i x3 presses -> freq_step_o 2,3, third press: no cfg_valid_o, stays 3; down mirrors at 1.
//   3-cycle pulse on btn_up_i -> no event, freq unchanged; 5-cycle pulse -> freq+1.
//   mode+up rise same cycle -> only wave_sel_o+1; hold cfg_ready_i=0 8 cycles: valid/outputs stable, new presses dropped.
//   Assert rstn_i low while cfg_valid_o=1 -> all outputs at reset values same cycle; INIT handshake repeats.

Source files
------------

// File: rtl/fg_input_controller_if.sv
// Configuration bus between the front-panel controller and the waveform core.
// The controller drives the config and valid; the core returns ready.
interface fg_input_controller_if #(
  parameter int FREQ_W = 8
) ();
  logic [1:0]        wave_sel_o;
  logic [FREQ_W-1:0] freq_step_o;
  logic              cfg_valid_o;
  logic              cfg_ready_i;
  logic              busy_o;

  modport master (
    output wave_sel_o,
    output freq_step_o,
    output cfg_valid_o,
    output busy_o,
    input  cfg_ready_i
  );

  modport slave (
    input  wave_sel_o,
    input  freq_step_o,
    input  cfg_valid_o,
    input  busy_o,
    output cfg_ready_i
  );
endinterface

// File: rtl/fg_input_controller.sv
// Front-panel controller: sync/debounce/edge-detect three buttons, step waveform/frequency,
// and offer each new configuration to the core; events seen while a config is pending are dropped.
module fg_input_controller #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int WAVE_NUM        = 4,
  parameter int FREQ_W          = 8,
  parameter int FREQ_MIN        = 1,
  parameter int FREQ_MAX        = 255
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  btn_mode_i,
  input  logic                  btn_up_i,
  input  logic                  btn_down_i,
  fg_input_controller_if.master cfg
);

  localparam int                CNT_W     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]        WAVE_LAST = 2'(WAVE_NUM - 1);
  localparam logic [FREQ_W-1:0] F_MIN     = FREQ_W'(FREQ_MIN);
  localparam logic [FREQ_W-1:0] F_MAX     = FREQ_W'(FREQ_MAX);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_SEND
  } state_t;

  // Button index: 0 = mode, 1 = up, 2 = down (also the event priority order).
  logic [2:0]             w_btn;
  logic [SYNC_STAGES-1:0] r_sync [3];
  logic [2:0]             w_sync;
  logic [CNT_W-1:0]       r_cnt  [3];
  logic [2:0]             r_stable;
  logic [2:0]             r_stable_d;
  logic [2:0]             w_evt;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_wave;
  logic [1:0]        w_wave_nxt;
  logic [FREQ_W-1:0] r_freq;
  logic [FREQ_W-1:0] w_freq_nxt;
  logic              r_cfg_valid;

  assign w_btn = {btn_down_i, btn_up_i, btn_mode_i};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_sync[i] = r_sync[i][SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < 3; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_btn[i]};
      end
    end
  end

  // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= '0;
      end
      r_stable   <= '0;
      r_stable_d <= '0;
    end else begin
      r_stable_d <= r_stable;
      for (int i = 0; i < 3; i++) begin
        if (w_sync[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_stable[i] <= w_sync[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_evt = r_stable & ~r_stable_d;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= ST_INIT;
      r_wave      <= '0;
      r_freq      <= F_MIN;
      r_cfg_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wave      <= w_wave_nxt;
      r_freq      <= w_freq_nxt;
      r_cfg_valid <= (w_state_nxt == ST_SEND);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wave_nxt  = r_wave;
    w_freq_nxt  = r_freq;
    case (r_state)
      ST_INIT: begin
        w_state_nxt = ST_SEND;
      end
      ST_IDLE: begin
        // Only the highest-priority event is considered; a saturated step is a no-op.
        if (w_evt[0]) begin
          w_wave_nxt  = (r_wave == WAVE_LAST) ? 2'd0 : r_wave + 2'd1;
          w_state_nxt = ST_SEND;
        end else if (w_evt[1]) begin
          if (r_freq != F_MAX) begin
            w_freq_nxt  = r_freq + 1'b1;
            w_state_nxt = ST_SEND;
          end
        end else if (w_evt[2]) begin
          if (r_freq != F_MIN) begin
            w_freq_nxt  = r_freq - 1'b1;
            w_state_nxt = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (cfg.cfg_ready_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  assign cfg.wave_sel_o  = r_wave;
  assign cfg.freq_step_o = r_freq;
  assign cfg.cfg_valid_o = r_cfg_valid;
  assign cfg.busy_o      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fg_input_controller.sv
// Scoreboarded bench for fg_input_controller: stimulus pushes expected configs,
// a monitor pops and compares them on every completed handshake.
module tb_fg_input_controller;

  logic clk_i      = 1'b0;
  logic rstn_i     = 1'b1;
  logic btn_mode_i = 1'b0;
  logic btn_up_i   = 1'b0;
  logic btn_down_i = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  int n_hs  = 0;

  logic [9:0] exp_q [$];

  always #5 clk_i = ~clk_i;

  fg_input_controller_if #(.FREQ_W(8)) cfg ();

  fg_input_controller #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .WAVE_NUM       (4),
    .FREQ_W         (8),
    .FREQ_MIN       (1),
    .FREQ_MAX       (3)
  ) dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .btn_mode_i(btn_mode_i),
    .btn_up_i  (btn_up_i),
    .btn_down_i(btn_down_i),
    .cfg       (cfg)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int wave, input int freq);
    logic [9:0] e;
    e = {wave[1:0], freq[7:0]};
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted config must match the oldest expectation.
  always @(negedge clk_i) begin
    if (rstn_i && cfg.cfg_valid_o === 1'b1 && cfg.cfg_ready_i === 1'b1) begin
      logic [9:0] e;
      n_hs++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_cfg: got wave=%0d freq=%0d, expected no handshake",
                 cfg.wave_sel_o, cfg.freq_step_o);
      end else begin
        e = exp_q.pop_front();
        chk("cfg_wave", int'(cfg.wave_sel_o), int'(e[9:8]));
        chk("cfg_freq", int'(cfg.freq_step_o), int'(e[7:0]));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  // which: bit0 mode, bit1 up, bit2 down
  task automatic press(input int which, input int hold);
    btn_mode_i = which[0];
    btn_up_i   = which[1];
    btn_down_i = which[2];
    cyc(hold);
    btn_mode_i = 1'b0;
    btn_up_i   = 1'b0;
    btn_down_i = 1'b0;
    cyc(12);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    @(negedge clk_i);
    while (cfg.busy_o !== 1'b0 && k < 60) begin
      @(negedge clk_i);
      k++;
    end
    chk({name, "_busy"}, int'(cfg.busy_o), 0);
    chk({name, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    @(negedge clk_i);
    while (cfg.cfg_valid_o !== 1'b1 && k < 40) begin
      @(negedge clk_i);
      k++;
    end
    chk({name, "_valid"}, int'(cfg.cfg_valid_o), 1);
  endtask

  initial begin
    cfg.cfg_ready_i = 1'b0;
    #1 rstn_i = 1'b0;
    cyc(3);
    chk("rst_wave",  int'(cfg.wave_sel_o), 0);
    chk("rst_freq",  int'(cfg.freq_step_o), 1);
    chk("rst_valid", int'(cfg.cfg_valid_o), 0);
    chk("rst_busy",  int'(cfg.busy_o), 1);

    // Default config published once after reset release.
    cfg.cfg_ready_i = 1'b1;
    push_exp(0, 1);
    rstn_i = 1'b1;
    wait_idle("init");
    cyc(1);

    // Mode presses wrap the waveform index.
    push_exp(1, 1); press(1, 10);
    push_exp(2, 1); press(1, 10);
    push_exp(3, 1); press(1, 10);
    push_exp(0, 1); press(1, 10);
    wait_idle("mode");
    chk("mode_wave", int'(cfg.wave_sel_o), 0);
    cyc(1);

    // Up saturates at 3, down saturates at 1.
    push_exp(0, 2); press(2, 10);
    push_exp(0, 3); press(2, 10);
    press(2, 10);
    wait_idle("up_sat");
    chk("up_sat_freq", int'(cfg.freq_step_o), 3);
    cyc(1);
    push_exp(0, 2); press(4, 10);
    push_exp(0, 1); press(4, 10);
    press(4, 10);
    wait_idle("dn_sat");
    chk("dn_sat_freq", int'(cfg.freq_step_o), 1);
    cyc(1);

    // Short glitch rejected, just-long-enough pulse accepted.
    press(2, 3);
    wait_idle("glitch");
    chk("glitch_freq", int'(cfg.freq_step_o), 1);
    cyc(1);
    push_exp(0, 2); press(2, 5);
    wait_idle("pulse5");
    chk("pulse5_freq", int'(cfg.freq_step_o), 2);
    cyc(1);

    // Simultaneous mode+up: mode wins.
    push_exp(1, 2); press(3, 10);
    wait_idle("prio");
    chk("prio_wave", int'(cfg.wave_sel_o), 1);
    chk("prio_freq", int'(cfg.freq_step_o), 2);
    cyc(1);

    // Backpressure: config held, presses during SEND dropped.
    cfg.cfg_ready_i = 1'b0;
    push_exp(2, 2);
    btn_mode_i = 1'b1;
    wait_valid("hold");
    btn_mode_i = 1'b0;
    btn_up_i   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk("hold_valid", int'(cfg.cfg_valid_o), 1);
      chk("hold_wave",  int'(cfg.wave_sel_o), 2);
      chk("hold_freq",  int'(cfg.freq_step_o), 2);
    end
    cyc(1);
    cfg.cfg_ready_i = 1'b1;
    cyc(2);
    btn_up_i = 1'b0;
    cyc(12);
    wait_idle("hold_end");
    chk("drop_freq", int'(cfg.freq_step_o), 2);
    cyc(1);

    // Reset while a config is pending.
    cfg.cfg_ready_i = 1'b0;
    push_exp(3, 2);
    btn_mode_i = 1'b1;
    wait_valid("mid");
    #2;
    rstn_i     = 1'b0;
    btn_mode_i = 1'b0;
    #1;
    chk("mid_rst_valid", int'(cfg.cfg_valid_o), 0);
    chk("mid_rst_wave",  int'(cfg.wave_sel_o), 0);
    chk("mid_rst_freq",  int'(cfg.freq_step_o), 1);
    chk("mid_rst_busy",  int'(cfg.busy_o), 1);
    exp_q.delete();
    cfg.cfg_ready_i = 1'b1;
    push_exp(0, 1);
    cyc(2);
    rstn_i = 1'b1;
    wait_idle("reinit");
    chk("reinit_wave", int'(cfg.wave_sel_o), 0);
    chk("reinit_freq", int'(cfg.freq_step_o), 1);

    cyc(4);
    chk("handshakes", n_hs, 13);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
